// File: rtl/dcache_flush_sequencer.sv
// rtl/dcache_flush_sequencer.sv - walks every D-cache line on a syscall, writing back dirty lines and invalidating valid ones.
// Optional FLUSH_STATS_EN adds write-back and cycle counters for the last flush.
module dcache_flush_sequencer #(
    parameter int NUM_LINES = 64,
    parameter int INDEX_W   = 6,
    parameter int TAG_W     = 21
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               sys_req,
    output logic               flush_busy,
    output logic               SYS,
    output logic [INDEX_W-1:0] line_index_2DC,
    output logic               line_read_2DC,
    input  logic               line_valid_fDC,
    input  logic               line_dirty_fDC,
    input  logic [TAG_W-1:0]   line_tag_fDC,
    input  logic [255:0]       line_data_fDC,
    output logic               line_invalidate_2DC,
    output logic               dBlkWrite,
    output logic [255:0]       block_write_2DM,
    output logic [31:0]        block_address_2DM,
    input  logic               block_write_fDM_valid
`ifdef FLUSH_STATS_EN
    ,
    output logic [15:0]        lines_written_OUT,
    output logic [31:0]        flush_cycles_OUT
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CHK  = 3'd2,
        WB   = 3'd3,
        INV  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_LINES - 1);

    state_t state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state               <= IDLE;
            line_index_2DC      <= '0;
            flush_busy          <= 1'b0;
            SYS                 <= 1'b0;
            line_read_2DC       <= 1'b0;
            line_invalidate_2DC <= 1'b0;
            dBlkWrite           <= 1'b0;
            block_write_2DM     <= '0;
            block_address_2DM   <= '0;
`ifdef FLUSH_STATS_EN
            lines_written_OUT   <= '0;
            flush_cycles_OUT    <= '0;
`endif
        end else begin
            line_read_2DC       <= 1'b0;
            line_invalidate_2DC <= 1'b0;
`ifdef FLUSH_STATS_EN
            // Counts only walk cycles, so the value freezes once DONE is reached.
            if ((state == RD || state == CHK || state == WB || state == INV)
                && flush_cycles_OUT != '1)
                flush_cycles_OUT <= flush_cycles_OUT + 32'd1;
`endif
            case (state)
                IDLE: begin
                    if (sys_req) begin
                        state          <= RD;
                        line_index_2DC <= '0;
                        line_read_2DC  <= 1'b1;
                        flush_busy     <= 1'b1;
`ifdef FLUSH_STATS_EN
                        lines_written_OUT <= '0;
                        flush_cycles_OUT  <= '0;
`endif
                    end
                end
                RD: state <= CHK;
                CHK: begin
                    if (line_valid_fDC && line_dirty_fDC) begin
                        block_address_2DM <= {line_tag_fDC, line_index_2DC, 5'b0};
                        block_write_2DM   <= line_data_fDC;
                        dBlkWrite         <= 1'b1;
                        state             <= WB;
                    end else if (line_valid_fDC) begin
                        line_invalidate_2DC <= 1'b1;
                        state               <= INV;
                    end else if (line_index_2DC == LAST_INDEX) begin
                        SYS   <= 1'b1;
                        state <= DONE;
                    end else begin
                        line_index_2DC <= line_index_2DC + 1'b1;
                        line_read_2DC  <= 1'b1;
                        state          <= RD;
                    end
                end
                WB: begin
                    if (block_write_fDM_valid) begin
                        dBlkWrite           <= 1'b0;
                        line_invalidate_2DC <= 1'b1;
                        state               <= INV;
`ifdef FLUSH_STATS_EN
                        if (lines_written_OUT != '1)
                            lines_written_OUT <= lines_written_OUT + 16'd1;
`endif
                    end
                end
                INV: begin
                    if (line_index_2DC == LAST_INDEX) begin
                        SYS   <= 1'b1;
                        state <= DONE;
                    end else begin
                        line_index_2DC <= line_index_2DC + 1'b1;
                        line_read_2DC  <= 1'b1;
                        state          <= RD;
                    end
                end
                DONE: begin
                    if (!sys_req) begin
                        SYS        <= 1'b0;
                        flush_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    SYS        <= 1'b0;
                    flush_busy <= 1'b0;
                    dBlkWrite  <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_flush_sequencer.sv
// tb/tb_dcache_flush_sequencer.sv - scoreboard bench: expected line events queued by stimulus, popped by a negedge monitor.
module tb_dcache_flush_sequencer;

    localparam logic [7:0] K_RD = 8'd1, K_INV = 8'd2, K_WB = 8'd3, K_DONE = 8'd4;

    typedef struct {
        logic [7:0]   kind;
        logic [31:0]  val;
        logic [255:0] data;
    } ev_t;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         sys_req;
    logic         flush_busy, SYS, line_read_2DC, line_invalidate_2DC, dBlkWrite;
    logic [5:0]   line_index_2DC;
    logic         line_valid_fDC = 1'b0, line_dirty_fDC = 1'b0;
    logic [20:0]  line_tag_fDC = '0;
    logic [255:0] line_data_fDC = '0;
    logic [255:0] block_write_2DM;
    logic [31:0]  block_address_2DM;
    logic         block_write_fDM_valid;
`ifdef FLUSH_STATS_EN
    logic [15:0]  lines_written_OUT;
    logic [31:0]  flush_cycles_OUT;
`endif

    logic         arr_v [64];
    logic         arr_d [64];
    logic [20:0]  arr_t [64];
    logic [255:0] arr_data [64];

    ev_t exp_q[$];
    int  n_cmp = 0, n_bad = 0;
    int  cyc = 0, start_cyc = 0;
    int  resp_n = 1;
    int  wb_cnt = 0;
    logic sys_q = 1'b0;

    dcache_flush_sequencer dut (
        .CLK(CLK), .RESET(RESET), .sys_req(sys_req),
        .flush_busy(flush_busy), .SYS(SYS),
        .line_index_2DC(line_index_2DC), .line_read_2DC(line_read_2DC),
        .line_valid_fDC(line_valid_fDC), .line_dirty_fDC(line_dirty_fDC),
        .line_tag_fDC(line_tag_fDC), .line_data_fDC(line_data_fDC),
        .line_invalidate_2DC(line_invalidate_2DC), .dBlkWrite(dBlkWrite),
        .block_write_2DM(block_write_2DM), .block_address_2DM(block_address_2DM),
        .block_write_fDM_valid(block_write_fDM_valid)
`ifdef FLUSH_STATS_EN
        , .lines_written_OUT(lines_written_OUT), .flush_cycles_OUT(flush_cycles_OUT)
`endif
    );

    always #5 CLK = ~CLK;

    // Tag array answers a read strobe one cycle later; memory accepts on the resp_n-th WB cycle.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (line_read_2DC) begin
            line_valid_fDC <= arr_v[line_index_2DC];
            line_dirty_fDC <= arr_d[line_index_2DC];
            line_tag_fDC   <= arr_t[line_index_2DC];
            line_data_fDC  <= arr_data[line_index_2DC];
        end
        wb_cnt <= dBlkWrite ? wb_cnt + 1 : 0;
    end
    assign block_write_fDM_valid = dBlkWrite && (wb_cnt == resp_n - 1);

    function automatic void check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(input logic [7:0] kind, input logic [31:0] val, input logic [255:0] data);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic ev_t pop_ev();
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 1, 0);
            e.kind = 8'hFF;
            e.val  = '0;
            e.data = '0;
        end else begin
            e = exp_q.pop_front();
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        ev_t e;
        if (line_read_2DC || line_invalidate_2DC)
            check("rd_inv_exclusive", line_read_2DC & line_invalidate_2DC, 0);
        if (line_read_2DC) begin
            e = pop_ev();
            check("read_index", {K_RD, 26'd0, line_index_2DC}, {e.kind, e.val});
        end
        if (line_invalidate_2DC) begin
            e = pop_ev();
            check("inv_index", {K_INV, 26'd0, line_index_2DC}, {e.kind, e.val});
        end
        if (dBlkWrite) begin
            e = pop_ev();
            check("wb_addr", {K_WB, block_address_2DM}, {e.kind, e.val});
            check("wb_data", block_write_2DM, e.data);
        end
        if (SYS && !sys_q) begin
            e = pop_ev();
            check("sys_cycle", {K_DONE, 32'(cyc - start_cyc)}, {e.kind, e.val});
        end
        sys_q = SYS;
    end

    task automatic clear_arr();
        for (int i = 0; i < 64; i++) begin
            arr_v[i] = 1'b0; arr_d[i] = 1'b0; arr_t[i] = '0; arr_data[i] = '0;
        end
    endtask

    task automatic set_line(input int idx, input logic dirty, input logic [20:0] tag, input logic [255:0] data);
        arr_v[idx] = 1'b1; arr_d[idx] = dirty; arr_t[idx] = tag; arr_data[idx] = data;
    endtask

    // Event order of a full walk; done_at is the hand-computed SYS edge.
    task automatic push_flush(input int done_at);
        for (int i = 0; i < 64; i++) begin
            push_ev(K_RD, 32'(i), '0);
            if (arr_v[i] && arr_d[i])
                for (int k = 0; k < resp_n; k++)
                    push_ev(K_WB, {arr_t[i], 6'(i), 5'b0}, arr_data[i]);
            if (arr_v[i])
                push_ev(K_INV, 32'(i), '0);
        end
        push_ev(K_DONE, 32'(done_at), '0);
    endtask

    task automatic wait_sys();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!SYS && n < 2000);
        if (!SYS) check("sys_timeout", 0, 1);
    endtask

    task automatic flush(input bit hold);
        sys_req = 1'b1;
        start_cyc = cyc + 1;
        if (!hold) begin
            @(negedge CLK);
            sys_req = 1'b0;
        end
        wait_sys();
        check("busy_in_done", flush_busy, 1);
        if (hold) sys_req = 1'b0;
        @(negedge CLK);
        check("sys_after_done", SYS, 0);
        check("busy_after_done", flush_busy, 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int w, n;
        RESET = 1'b1;
        sys_req = 1'b0;
        clear_arr();
        repeat (3) @(negedge CLK);
        check("rst_busy", flush_busy, 0);
        check("rst_sys", SYS, 0);
        check("rst_read", line_read_2DC, 0);
        check("rst_inv", line_invalidate_2DC, 0);
        check("rst_blkwrite", dBlkWrite, 0);
        check("rst_wdata", block_write_2DM, 0);
        check("rst_waddr", block_address_2DM, 0);
        check("rst_index", line_index_2DC, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // All lines invalid: 64 x 2 cycles.
        clear_arr();
        resp_n = 1;
        push_flush(128);
        flush(1);

        // Line 5 clean (+1), line 9 dirty with 3 WB cycles (+1+3).
        clear_arr();
        set_line(5, 1'b0, 21'h00111, {8{32'h5A5A5A5A}});
        set_line(9, 1'b1, 21'h0ABCD, {8{32'hA5A5A5A5}});
        resp_n = 3;
        push_flush(133);
        flush(1);

        // Last line dirty, accepted in the first WB cycle (+1+1), no wrap.
        clear_arr();
        set_line(63, 1'b1, 21'h1FFFFF, {4{64'h0123456789ABCDEF}});
        resp_n = 1;
        push_flush(130);
        flush(1);

        // Reset during the second WB cycle of line 2.
        clear_arr();
        set_line(2, 1'b1, 21'h12345, {16{16'hBEEF}});
        resp_n = 100;
        for (int i = 0; i < 3; i++) push_ev(K_RD, 32'(i), '0);
        for (int i = 0; i < 2; i++) push_ev(K_WB, {21'h12345, 6'd2, 5'b0}, {16{16'hBEEF}});
        sys_req = 1'b1;
        start_cyc = cyc + 1;
        w = 0;
        n = 0;
        while (w < 2 && n < 500) begin
            @(negedge CLK);
            n++;
            if (dBlkWrite) w++;
        end
        check("wb_cycles_before_reset", w, 2);
        RESET = 1'b1;
        sys_req = 1'b0;
        @(negedge CLK);
        check("abort_blkwrite", dBlkWrite, 0);
        check("abort_busy", flush_busy, 0);
        check("abort_sys", SYS, 0);
        check("abort_index", line_index_2DC, 0);
        check("abort_queue_drained", exp_q.size(), 0);
        RESET = 1'b0;
        @(negedge CLK);
        resp_n = 1;
        push_flush(130);
        flush(1);

        // One-cycle sys_req pulse: walk still completes, SYS lasts one cycle.
        clear_arr();
        push_flush(128);
        flush(0);

`ifdef FLUSH_STATS_EN
        // 61 invalid x 2 + 3 dirty x (3 + 2) = 137.
        clear_arr();
        set_line(10, 1'b1, 21'h00010, {8{32'h10101010}});
        set_line(20, 1'b1, 21'h00020, {8{32'h20202020}});
        set_line(30, 1'b1, 21'h00030, {8{32'h30303030}});
        resp_n = 2;
        push_flush(137);
        flush(1);
        check("stats_lines_written", lines_written_OUT, 3);
        check("stats_flush_cycles", flush_cycles_OUT, 137);
`endif

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
